crossbar_struct_2x2: RTL and testbench



---
 rtl/crossbar_struct_2x2.sv | 78 +++++++
 tb/tb_crossbar_struct_2x2.sv | 135 +++++++++++++
 2 files changed

// File: rtl/crossbar_struct_2x2.sv
// crossbar_struct_2x2 -- 2-in / 2-out registered crossbar built from
// gate-level 2:1 mux cells, one cell per bit per output.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous reset, active-low (outputs load zero)
//   in1     data lane 1 [WIDTH]
//   in2     data lane 2 [WIDTH]
//   select  routing control: 0 = pass, 1 = swap
//           (2 bits when CROSSBAR_BROADCAST_EN is defined:
//            00 pass, 01 swap, 10 broadcast in1, 11 broadcast in2)
//   out1    registered output lane 1 [WIDTH]
//   out2    registered output lane 2 [WIDTH]
//
// Optional feature macro: CROSSBAR_BROADCAST_EN

// Gate-level 2:1 mux: y = (a & ~s) | (b & s)
module crossbar_mux2_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = (a & ~s) | (b & s);
endmodule

module crossbar_struct_2x2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
`ifdef CROSSBAR_BROADCAST_EN
  input  logic [1:0]       select,
`else
  input  logic             select,
`endif
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2
);

  logic [WIDTH-1:0] nxt1, nxt2;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
`ifdef CROSSBAR_BROADCAST_EN
      // 4:1 per output from three cells: select[0] picks within the
      // pass/swap pair and within the broadcast pair, select[1] picks
      // between the pairs.
      logic lo1, hi1, lo2, hi2;
      crossbar_mux2_cell u_lo1 (.a(in1[i]), .b(in2[i]), .s(select[0]), .y(lo1));
      crossbar_mux2_cell u_hi1 (.a(in1[i]), .b(in2[i]), .s(select[0]), .y(hi1));
      crossbar_mux2_cell u_o1  (.a(lo1),    .b(hi1),    .s(select[1]), .y(nxt1[i]));
      crossbar_mux2_cell u_lo2 (.a(in2[i]), .b(in1[i]), .s(select[0]), .y(lo2));
      crossbar_mux2_cell u_hi2 (.a(in1[i]), .b(in2[i]), .s(select[0]), .y(hi2));
      crossbar_mux2_cell u_o2  (.a(lo2),    .b(hi2),    .s(select[1]), .y(nxt2[i]));
`else
      crossbar_mux2_cell u_o1 (.a(in1[i]), .b(in2[i]), .s(select), .y(nxt1[i]));
      crossbar_mux2_cell u_o2 (.a(in2[i]), .b(in1[i]), .s(select), .y(nxt2[i]));
`endif
    end
  endgenerate

  // Select and data are sampled together at the same edge, so a cycle
  // can never pair an old routing decision with new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out1 <= '0;
      out2 <= '0;
    end else begin
      out1 <= nxt1;
      out2 <= nxt2;
    end
  end

endmodule

// File: tb/tb_crossbar_struct_2x2.sv
// Directed bench for crossbar_struct_2x2: a WIDTH=1 and a WIDTH=8 instance
// share clock, reset and select; expected values are hand-computed.
module tb_crossbar_struct_2x2;

`ifdef CROSSBAR_BROADCAST_EN
  localparam int SW = 2;
`else
  localparam int SW = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sel;
  logic          a1, b1;
  logic          o1_1, o2_1;
  logic [7:0]    a8, b8;
  logic [7:0]    o1_8, o2_8;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  crossbar_struct_2x2 #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in1(a1), .in2(b1), .select(sel),
    .out1(o1_1), .out2(o2_1)
  );

  crossbar_struct_2x2 #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in1(a8), .in2(b8), .select(sel),
    .out1(o1_8), .out2(o2_8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held two cycles with all inputs active
    rst_n = 1'b0; a1 = 1'b1; b1 = 1'b1; sel = 1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    chk("rst1_w1", {6'd0, o2_1, o1_1}, 8'h00);
    chk("rst1_out1", o1_8, 8'h00);
    chk("rst1_out2", o2_8, 8'h00);
    tick();
    chk("rst2_w1", {6'd0, o2_1, o1_1}, 8'h00);
    chk("rst2_out1", o1_8, 8'h00);
    chk("rst2_out2", o2_8, 8'h00);

    // Pass, WIDTH=1
    rst_n = 1'b1; sel = 0; a1 = 1'b1; b1 = 1'b0;
    tick();
    chk("pass_001", {6'd0, o2_1, o1_1}, 8'h01);
    a1 = 1'b0; b1 = 1'b1;
    #1;
    chk("pass_hold", {6'd0, o2_1, o1_1}, 8'h01);
    tick();
    chk("pass_010", {6'd0, o2_1, o1_1}, 8'h02);

    // Swap, WIDTH=1
    sel = 1; a1 = 1'b1; b1 = 1'b0;
    #1;
    chk("swap_hold", {6'd0, o2_1, o1_1}, 8'h02);
    tick();
    chk("swap_101", {6'd0, o2_1, o1_1}, 8'h02);
    a1 = 1'b0; b1 = 1'b1;
    #1;
    chk("swap_hold2", {6'd0, o2_1, o1_1}, 8'h02);
    tick();
    chk("swap_110", {6'd0, o2_1, o1_1}, 8'h01);

    // Multi-bit pass then swap
    sel = 0; a8 = 8'hA5; b8 = 8'h3C;
    tick();
    chk("w8_pass_out1", o1_8, 8'hA5);
    chk("w8_pass_out2", o2_8, 8'h3C);
    sel = 1;
    tick();
    chk("w8_swap_out1", o1_8, 8'h3C);
    chk("w8_swap_out2", o2_8, 8'hA5);

    // Mixed bit pattern exercises per-bit independence
    sel = 0; a8 = 8'h0F; b8 = 8'hF0;
    tick();
    chk("w8_mix_pass1", o1_8, 8'h0F);
    chk("w8_mix_pass2", o2_8, 8'hF0);

    // Mid-operation reset during swap
    sel = 1; a8 = 8'hFF; b8 = 8'h00;
    tick();
    chk("mid_swap_out1", o1_8, 8'h00);
    chk("mid_swap_out2", o2_8, 8'hFF);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out1", o1_8, 8'h00);
    chk("mid_rst_out2", o2_8, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("mid_resume_out1", o1_8, 8'h00);
    chk("mid_resume_out2", o2_8, 8'hFF);

`ifdef CROSSBAR_BROADCAST_EN
    a8 = 8'h11; b8 = 8'h22;
    sel = 2'd2;
    tick();
    chk("bc_in1_out1", o1_8, 8'h11);
    chk("bc_in1_out2", o2_8, 8'h11);
    sel = 2'd3;
    tick();
    chk("bc_in2_out1", o1_8, 8'h22);
    chk("bc_in2_out2", o2_8, 8'h22);
    sel = 2'd0;
    tick();
    chk("bc_pass_out1", o1_8, 8'h11);
    chk("bc_pass_out2", o2_8, 8'h22);
    sel = 2'd1;
    tick();
    chk("bc_swap_out1", o1_8, 8'h22);
    chk("bc_swap_out2", o2_8, 8'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
